// File: rtl/mau_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, fault codes,
// sequencer states and the byte-enable patterns the data memory expects.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mau_be_gen.sv
// Combinational size/address decode into byte enables and a fault code.
// A faulting request yields BE_NONE so nothing downstream can touch memory.
module mau_be_gen
    import mau_pkg::*;
#(
    parameter int DM_ADDR_W = 12
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic [3:0]  be,
    output logic [1:0]  err_code
);

    logic out_of_range;
    logic misaligned;
    logic unused_mid_bits;

    assign out_of_range    = |addr[31:DM_ADDR_W];
    assign unused_mid_bits = ^addr[DM_ADDR_W-1:2];

    always_comb begin
        misaligned = 1'b0;
        be         = BE_NONE;
        case (size_e'(size))
            SZ_BYTE: be = BE_BYTE0 << addr[1:0];
            SZ_HALF: begin
                be         = addr[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr[0];
            end
            SZ_WORD: begin
                be         = BE_WORD;
                misaligned = |addr[1:0];
            end
            default: be = BE_NONE;
        endcase

        // Priority: illegal size, then range, then alignment.
        if (size_e'(size) == SZ_ILL)
            err_code = ERR_SIZE;
        else if (out_of_range)
            err_code = ERR_RANGE;
        else if (misaligned)
            err_code = ERR_MISALIGN;
        else
            err_code = ERR_NONE;

        if (err_code != ERR_NONE)
            be = BE_NONE;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory: accepts one request,
// drives a single ACCESS cycle, then reports completion or fault.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DM_ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] dm_dout_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] rdata_o,
    output logic [9:0]  dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_din_o,
    output logic        dm_wr_o,
    output logic        dm_signed_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a request is taken on any rising edge where req_i=1 and
    // busy_o=0; fields need only be valid in that cycle, and req_i while
    // busy_o=1 is dropped, never queued.
    state_e      state_q, state_d;
    logic        accept;
    logic        fault_q;
    logic        we_q;
    logic        signed_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic [3:0]  be_dec;
    logic [1:0]  code_q;
    logic [1:0]  code_dec;

    mau_be_gen #(.DM_ADDR_W(DM_ADDR_W)) u_be_gen (
        .size     (size_i),
        .addr     (addr_i),
        .be       (be_dec),
        .err_code (code_dec)
    );

    assign accept  = (state_q == ST_IDLE) && req_i;
    assign fault_q = (code_q != ERR_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Faults also spend one cycle in ACCESS (with memory untouched) so that
    // every request completes at the same latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_i) state_d = ST_ACCESS;
            ST_ACCESS: state_d = fault_q ? ST_FAULT : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q != ST_IDLE);
        done_o  = 1'b0;
        err_o   = 1'b0;
        dm_wr_o = 1'b0;
        dm_be_o = BE_NONE;
        case (state_q)
            ST_ACCESS: begin
                dm_be_o = be_q;
                dm_wr_o = we_q & ~fault_q;
            end
            ST_DONE:  done_o = 1'b1;
            ST_FAULT: begin
                done_o = 1'b1;
                err_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= BE_NONE;
            code_q   <= ERR_NONE;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= we_i;
                signed_q <= signed_i;
                addr_q   <= addr_i[11:2];
                wdata_q  <= wdata_i;
                be_q     <= be_dec;
                code_q   <= code_dec;
            end
            if (state_q == ST_ACCESS && !we_q && !fault_q)
                rdata_q <= dm_dout_i;
        end
    end

    assign err_code_o  = code_q;
    assign rdata_o     = rdata_q;
    assign dm_addr_o   = addr_q;
    assign dm_din_o    = wdata_q;
    assign dm_signed_o = signed_q;
    assign dbg_state_o = state_q;

endmodule
